mem_port_scheduler: RTL and testbench
=====================================

// Module: mem_port_scheduler
// PURPOSE
//  Shares the single byte-serial RAM/IO port between instruction fetch (ICache) and the load/store buffer (LSB).
//  Sequences multi-byte reads/writes one byte per cycle; sign/zero-extends loads.
//  Holds IO stores while the IO buffer is full; aborts speculative reads on flush.
//  Sits between ICache/LSB and the top-level mem_a/mem_din/mem_dout/mem_wr pins.
// PARAMETERS
//  IO_BASE      32'h0003_0000  addresses >= IO_BASE are IO-mapped
//  STARVE_LIMIT 4              consecutive LSB grants before IC is forced (guard only)
// PORTS
//  clk_in          in   1   clock, single domain
//  rst_in          in   1   reset, asynchronous, active-high
//  rdy_in          in   1   global enable; low = freeze
//  clr_in          in   1   pipeline flush (mispredict)
//  io_buffer_full  in   1   IO write buffer full
//  mem_din         in   8   read byte; valid 1 cycle after its address
//  mem_dout        out  8   write byte
//  mem_a           out  32  byte address
//  mem_wr          out  1   1 = write cycle
//  ic_req          in   1   fetch request, held until ic_rdy
//  ic_pc           in   32  fetch address (word)
//  ic_rdy          out  1   1-cycle pulse, ic_data valid
//  ic_data         out  32  fetched word
//  lsb_req         in   1   mem op request, held until lsb_rdy
//  lsb_wr          in   1   1 = store
//  lsb_size        in   2   00 byte, 01 half, 10 word
//  lsb_signed      in   1   sign-extend load
//  lsb_addr        in   32  byte address
//  lsb_wdata       in   32  store data (low bytes used)
//  lsb_rdy         out  1   1-cycle pulse, op done / lsb_data valid
//  lsb_data        out  32  extended load data
// BEHAVIOUR
//  Reset: state IDLE; mem_a, mem_dout, mem_wr, ic_rdy, lsb_rdy, ic_data, lsb_data, counters = 0.
//  rdy_in=0: all registers incl. outputs hold; resume exactly where frozen.
//  FSM IDLE/IFETCH/LOAD/STORE. IDLE never accepts in a cycle where ic_rdy or lsb_rdy is high.
//  Arbitration in IDLE: lsb_req wins over ic_req. IO store (lsb_wr, addr>=IO_BASE) with io_buffer_full
//   is not accepted; IC may be granted instead; store retried once buffer not full.
//  N = 1/2/4 bytes (fetch N=4). Accept edge E0 latches op, drives mem_a=A.
//  Read: edge Ek (k=1..N) captures mem_din as byte k-1, mem_a=A+k; after EN, rdy pulses, data valid, mem_a=0, ->IDLE.
//   Latency: rdy high N cycles after accept.
//  Store: E0 drives mem_wr=1, mem_dout=byte0; Ek drives byte k, mem_a=A+k; after EN mem_wr=0, lsb_rdy pulse, ->IDLE.
//  Little-endian; byte k = data[8k+7:8k]. Addresses wrap mod 2^32. Load ext per lsb_size/lsb_signed, e.g. 0x80 signed byte -> 0xFFFFFF80.
//  clr_in=1: IFETCH/LOAD abort -> IDLE at that edge, no rdy, partial data discarded;
//   STORE always completes and pulses lsb_rdy (committed). No accept on a clr_in cycle.
//  rst_in mid-op: immediate abort to reset values, partial store bytes stay written.
// CONFIGURATION
//  MEM_SCHED_STARVE_GUARD_EN defined: count consecutive LSB grants made while ic_req high;
//   at STARVE_LIMIT next grant goes to IC; counter clears on any IC grant or ic_req low.
//  Undefined: fixed LSB priority, no counter logic.
// STRUCTURE
//  consts.v: state codes, size codes (SZ_B/SZ_H/SZ_W), IO_BASE default.
//  Sub-module mem_sched_arb: IDLE grant decision + starvation counter (guard lives here).
//  Byte sequencing, extension and FSM in the top module.
// TESTING
//  IC fetch 0x1000, RAM 11 22 33 44 -> ic_rdy 4 cycles after accept, ic_data=0x44332211.
//  Both req same cycle (lsb load byte 0x2000=0x80 signed) -> LSB first, lsb_data=0xFFFFFF80, then IC.
//  Store half 0xBEEF to 0x31, wait -> mem_wr 2 cycles: (0x31,EF),(0x32,BE); lsb_rdy after.
//  IO store to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr; write after full drops.
//  clr_in at 2nd byte of fetch -> no ic_rdy, IDLE next; clr during store -> store completes.
//  Guard on, lsb_req held, ic_req held -> IC granted after 4 LSB ops; guard off -> IC starves.

Source files
------------

// File: rtl/mem_port_scheduler_pkg.sv
// Shared state/size codes and helpers for the byte-serial memory port scheduler.
// Optional starvation guard is enabled with MEM_SCHED_STARVE_GUARD_EN (see mem_sched_arb).
package mem_port_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STORE  = 2'd3
  } state_e;

  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;

  localparam logic [31:0] IO_BASE_DEFAULT      = 32'h0003_0000;
  localparam int          STARVE_LIMIT_DEFAULT = 4;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_H:    r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_sched_arb.sv
// IDLE-state grant decision between instruction fetch and the load/store buffer.
// With MEM_SCHED_STARVE_GUARD_EN defined, a consecutive-LSB-grant counter forces an IC grant.
module mem_sched_arb
  import mem_port_scheduler_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        idle_i,
  input  logic        ic_req_i,
  input  logic        lsb_req_i,
  input  logic        lsb_wr_i,
  input  logic [31:0] lsb_addr_i,
  input  logic        io_full_i,
  output logic        grant_ic_o,
  output logic        grant_lsb_o
);

  // An IO store cannot start while the IO write buffer is full; it is simply retried later.
  logic lsb_ok;
  assign lsb_ok = lsb_req_i && !(lsb_wr_i && (lsb_addr_i >= IO_BASE) && io_full_i);

`ifdef MEM_SCHED_STARVE_GUARD_EN
  localparam int               CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]    LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          force_ic;

  assign force_ic    = ic_req_i && (starve_q >= LIMIT_C);
  assign grant_ic_o  = idle_i && ic_req_i && (!lsb_ok || force_ic);
  assign grant_lsb_o = idle_i && lsb_ok && !force_ic;

  always_comb begin
    starve_d = starve_q;
    if (!ic_req_i || grant_ic_o) begin
      starve_d = '0;
    end else if (grant_lsb_o && (starve_q < LIMIT_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (en_i) begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_lsb_o = idle_i && lsb_ok;
  assign grant_ic_o  = idle_i && ic_req_i && !lsb_ok;

  logic unused_cfg;
  assign unused_cfg = &{1'b0, clk_i, rst_i, en_i, (STARVE_LIMIT > 0)};
`endif

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the byte-serial RAM/IO port between ICache fetch and the LSB; sequences bytes and extends loads.
// Optional IC starvation guard: define MEM_SCHED_STARVE_GUARD_EN.
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        ic_req,
  input  logic [31:0] ic_pc,
  output logic        ic_rdy,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic        lsb_signed,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_rdy,
  output logic [31:0] lsb_data
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ic_rdy_q, ic_rdy_d;
  logic        lsb_rdy_q, lsb_rdy_d;
  logic [31:0] ic_data_q, ic_data_d;
  logic [31:0] lsb_data_q, lsb_data_d;

  logic        idle_ok, grant_ic, grant_lsb;
  logic [2:0]  cnt_next;
  logic        last;
  logic [31:0] merged;

  // The rdy pulse of the previous op must drop before anything new is accepted.
  assign idle_ok = (state_q == ST_IDLE) && !ic_rdy_q && !lsb_rdy_q && !clr_in;

  mem_sched_arb #(
    .IO_BASE      (IO_BASE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .en_i        (rdy_in),
    .idle_i      (idle_ok),
    .ic_req_i    (ic_req),
    .lsb_req_i   (lsb_req),
    .lsb_wr_i    (lsb_wr),
    .lsb_addr_i  (lsb_addr),
    .io_full_i   (io_buffer_full),
    .grant_ic_o  (grant_ic),
    .grant_lsb_o (grant_lsb)
  );

  assign cnt_next = cnt_q + 3'd1;
  assign last     = (cnt_next == nbytes_q);

  always_comb begin
    merged = buf_q;
    merged[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    signed_d   = signed_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ic_rdy_d   = 1'b0;
    lsb_rdy_d  = 1'b0;
    ic_data_d  = ic_data_q;
    lsb_data_d = lsb_data_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_lsb) begin
          addr_d   = lsb_addr;
          wdata_d  = lsb_wdata;
          size_d   = lsb_size;
          signed_d = lsb_signed;
          nbytes_d = size_bytes(lsb_size);
          cnt_d    = '0;
          buf_d    = '0;
          mem_a_d  = lsb_addr;
          if (lsb_wr) begin
            state_d    = ST_STORE;
            mem_wr_d   = 1'b1;
            mem_dout_d = lsb_wdata[7:0];
          end else begin
            state_d = ST_LOAD;
          end
        end else if (grant_ic) begin
          addr_d   = ic_pc;
          size_d   = SZ_W;
          signed_d = 1'b0;
          nbytes_d = 3'd4;
          cnt_d    = '0;
          buf_d    = '0;
          mem_a_d  = ic_pc;
          state_d  = ST_IFETCH;
        end
      end

      ST_IFETCH, ST_LOAD: begin
        if (clr_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          buf_d = merged;
          cnt_d = cnt_next;
          if (last) begin
            state_d = ST_IDLE;
            mem_a_d = '0;
            if (state_q == ST_IFETCH) begin
              ic_rdy_d  = 1'b1;
              ic_data_d = merged;
            end else begin
              lsb_rdy_d  = 1'b1;
              lsb_data_d = load_extend(merged, size_q, signed_q);
            end
          end else begin
            mem_a_d = addr_q + {29'd0, cnt_next};
          end
        end
      end

      ST_STORE: begin
        // Stores are already committed, so a flush never interrupts them.
        cnt_d = cnt_next;
        if (last) begin
          state_d    = ST_IDLE;
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          mem_dout_d = '0;
          lsb_rdy_d  = 1'b1;
        end else begin
          mem_a_d    = addr_q + {29'd0, cnt_next};
          mem_dout_d = wdata_q[{cnt_next[1:0], 3'b000} +: 8];
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_rdy_q   <= 1'b0;
      lsb_rdy_q  <= 1'b0;
      ic_data_q  <= '0;
      lsb_data_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_rdy_q   <= ic_rdy_d;
      lsb_rdy_q  <= lsb_rdy_d;
      ic_data_q  <= ic_data_d;
      lsb_data_q <= lsb_data_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign ic_rdy   = ic_rdy_q;
  assign ic_data  = ic_data_q;
  assign lsb_rdy  = lsb_rdy_q;
  assign lsb_data = lsb_data_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: sparse RAM model, write log, hand-computed expectations.
// Guard scenario expectations follow MEM_SCHED_STARVE_GUARD_EN.
module tb_mem_port_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clr_in = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        ic_req = 1'b0;
  logic [31:0] ic_pc = '0;
  logic        ic_rdy;
  logic [31:0] ic_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_size = 2'b00;
  logic        lsb_signed = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_rdy;
  logic [31:0] lsb_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  mem_port_scheduler dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clr_in         (clr_in),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .ic_req         (ic_req),
    .ic_pc          (ic_pc),
    .ic_rdy         (ic_rdy),
    .ic_data        (ic_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_size       (lsb_size),
    .lsb_signed     (lsb_signed),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_rdy        (lsb_rdy),
    .lsb_data       (lsb_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Read data follows the registered address, so it is valid the cycle after mem_a changes.
  always @(mem_a) mem_din = ram_rd(mem_a);

  always @(posedge clk_in) begin
    if (mem_wr && rdy_in && !rst_in) begin
      ram[mem_a] = mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
      $display("write a=%h d=%h", mem_a, mem_dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_rdy(input bit want_ic, output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cyc++;
      if (want_ic ? ic_rdy : lsb_rdy) break;
    end
  endtask

  task automatic lsb_op(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_cyc);
    int cyc;
    lsb_wr = wr; lsb_size = sz; lsb_signed = sg; lsb_addr = a; lsb_wdata = wd; lsb_req = 1'b1;
    wait_rdy(1'b0, cyc);
    lsb_req = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    tick();
  endtask

  task automatic ic_fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp_word);
    int cyc;
    ic_pc = pc; ic_req = 1'b1;
    wait_rdy(1'b1, cyc);
    ic_req = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'd5);
    check({tag, "_data"}, ic_data, exp_word);
    tick();
  endtask

  initial begin
    int cyc;
    int lsb_cnt;
    bit ic_seen;

    ram[32'h1000] = 8'h11; ram[32'h1001] = 8'h22;
    ram[32'h1002] = 8'h33; ram[32'h1003] = 8'h44;
    ram[32'h2000] = 8'h80; ram[32'h2002] = 8'h34; ram[32'h2003] = 8'hF2;

    // Reset values
    #2;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_ic_rdy", 32'(ic_rdy), 32'd0);
    check("rst_lsb_data", lsb_data, 32'h0);
    tick();
    rst_in = 1'b0;
    tick();

    // Plain fetch, with an explicit look at the accept edge
    ic_pc = 32'h1000; ic_req = 1'b1;
    tick();
    check("fetch_accept_a", mem_a, 32'h1000);
    wait_rdy(1'b1, cyc);
    ic_req = 1'b0;
    check("fetch_lat", 32'(cyc), 32'd4);
    check("fetch_data", ic_data, 32'h44332211);
    tick();
    check("fetch_rdy_pulse", 32'(ic_rdy), 32'd0);

    // Simultaneous requests: signed byte load goes first, fetch follows
    lsb_wr = 1'b0; lsb_size = 2'b00; lsb_signed = 1'b1; lsb_addr = 32'h2000; lsb_req = 1'b1;
    ic_pc = 32'h1000; ic_req = 1'b1;
    tick();
    check("both_lsb_first_a", mem_a, 32'h2000);
    tick();
    lsb_req = 1'b0;
    check("both_lsb_rdy", 32'(lsb_rdy), 32'd1);
    check("both_lsb_data", lsb_data, 32'hFFFFFF80);
    tick();
    check("both_gap_a", mem_a, 32'h0);
    tick();
    check("both_ic_accept_a", mem_a, 32'h1000);
    wait_rdy(1'b1, cyc);
    ic_req = 1'b0;
    check("both_ic_lat", 32'(cyc), 32'd4);
    check("both_ic_data", ic_data, 32'h44332211);
    tick();

    // Load extension variants
    lsb_op("ld_bu", 1'b0, 2'b00, 1'b0, 32'h2000, 32'h0, 2);
    check("ld_bu_data", lsb_data, 32'h00000080);
    lsb_op("ld_hs", 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 3);
    check("ld_hs_data", lsb_data, 32'hFFFFF234);
    lsb_op("ld_w", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 5);
    check("ld_w_data", lsb_data, 32'h44332211);

    // Half store: two write cycles then the rdy pulse
    wlog_a.delete(); wlog_d.delete();
    lsb_op("st_h", 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000BEEF, 3);
    check("st_h_count", 32'(wlog_a.size()), 32'd2);
    check("st_h_a0", wlog_a[0], 32'h31);
    check("st_h_d0", 32'(wlog_d[0]), 32'hEF);
    check("st_h_a1", wlog_a[1], 32'h32);
    check("st_h_d1", 32'(wlog_d[1]), 32'hBE);
    lsb_op("ld_hu", 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 3);
    check("ld_hu_data", lsb_data, 32'h0000BEEF);

    // IO store held while the buffer is full; IC may slip in meanwhile
    wlog_a.delete(); wlog_d.delete();
    io_buffer_full = 1'b1;
    lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h0003_0000; lsb_wdata = 32'hA5; lsb_req = 1'b1;
    repeat (5) tick();
    check("io_hold_writes", 32'(wlog_a.size()), 32'd0);
    check("io_hold_a", mem_a, 32'h0);
    ic_pc = 32'h1000; ic_req = 1'b1;
    tick();
    check("io_ic_granted_a", mem_a, 32'h1000);
    wait_rdy(1'b1, cyc);
    ic_req = 1'b0;
    check("io_ic_data", ic_data, 32'h44332211);
    tick();
    io_buffer_full = 1'b0;
    wait_rdy(1'b0, cyc);
    lsb_req = 1'b0;
    check("io_store_rdy", 32'(lsb_rdy), 32'd1);
    check("io_store_count", 32'(wlog_a.size()), 32'd1);
    check("io_store_a", wlog_a[0], 32'h0003_0000);
    check("io_store_d", 32'(wlog_d[0]), 32'hA5);
    tick();

    // Flush during fetch: no rdy, back to IDLE
    ic_pc = 32'h1000; ic_req = 1'b1;
    tick();
    tick();
    check("clr_fetch_a1", mem_a, 32'h1001);
    clr_in = 1'b1; ic_req = 1'b0;
    tick();
    clr_in = 1'b0;
    check("clr_fetch_idle_a", mem_a, 32'h0);
    ic_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ic_seen |= ic_rdy;
      tick();
    end
    check("clr_fetch_no_rdy", 32'(ic_seen), 32'd0);

    // No accept in a flush cycle
    clr_in = 1'b1; ic_pc = 32'h1000; ic_req = 1'b1;
    tick();
    check("clr_no_accept_a", mem_a, 32'h0);
    clr_in = 1'b0;
    wait_rdy(1'b1, cyc);
    ic_req = 1'b0;
    check("clr_after_lat", 32'(cyc), 32'd5);
    check("clr_after_data", ic_data, 32'h44332211);
    tick();

    // Flush during a word store: the store still finishes
    wlog_a.delete(); wlog_d.delete();
    lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h40; lsb_wdata = 32'hDEADBEEF; lsb_req = 1'b1;
    tick();
    tick();
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check("clr_st_wr", 32'(mem_wr), 32'd1);
    check("clr_st_a", mem_a, 32'h42);
    wait_rdy(1'b0, cyc);
    lsb_req = 1'b0;
    check("clr_st_lat", 32'(cyc), 32'd2);
    check("clr_st_count", 32'(wlog_a.size()), 32'd4);
    check("clr_st_a3", wlog_a[3], 32'h43);
    check("clr_st_d3", 32'(wlog_d[3]), 32'hDE);
    tick();
    lsb_op("ld_w2", 1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 5);
    check("ld_w2_data", lsb_data, 32'hDEADBEEF);

    // Freeze mid-fetch and resume
    ic_pc = 32'h1000; ic_req = 1'b1;
    tick();
    tick();
    rdy_in = 1'b0;
    repeat (3) tick();
    check("frz_a", mem_a, 32'h1001);
    check("frz_rdy", 32'(ic_rdy), 32'd0);
    rdy_in = 1'b1;
    wait_rdy(1'b1, cyc);
    ic_req = 1'b0;
    check("frz_lat", 32'(cyc), 32'd3);
    check("frz_data", ic_data, 32'h44332211);
    tick();

    // Starvation scenario
    lsb_wr = 1'b0; lsb_size = 2'b00; lsb_signed = 1'b0; lsb_addr = 32'h2000; lsb_req = 1'b1;
    ic_pc = 32'h1000; ic_req = 1'b1;
    lsb_cnt = 0; ic_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lsb_rdy) lsb_cnt++;
      if (ic_rdy) begin
        ic_seen = 1'b1;
        break;
      end
    end
    lsb_req = 1'b0; ic_req = 1'b0;
`ifdef MEM_SCHED_STARVE_GUARD_EN
    check("guard_ic_seen", 32'(ic_seen), 32'd1);
    check("guard_lsb_before_ic", 32'(lsb_cnt), 32'd4);
    check("guard_ic_data", ic_data, 32'h44332211);
`else
    check("starve_ic_seen", 32'(ic_seen), 32'd0);
    check("starve_lsb_ops", 32'(lsb_cnt > 10), 32'd1);
`endif
    repeat (6) tick();

    // Asynchronous reset mid-store: written byte stays, port returns to reset values
    wlog_a.delete(); wlog_d.delete();
    lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h50; lsb_wdata = 32'h11223344; lsb_req = 1'b1;
    tick();
    tick();
    rst_in = 1'b1;
    #1;
    check("rst_mid_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_a", mem_a, 32'h0);
    check("rst_mid_byte0", 32'(ram_rd(32'h50)), 32'h44);
    check("rst_mid_byte1", 32'(ram_rd(32'h51)), 32'h00);
    lsb_req = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
